param_data_mem: RTL
===================

Name: param_data_mem

Overview:
- Parametrised successor to the fixed 18x32 data memory used by the matrix-multiplication datapath for operand and result storage.
- Width, depth and the valid-address bound are configurable. Reads are registered, 1-cycle latency, with a valid strobe.
- Memory is cleared by a sequential sweep engine instead of a one-cycle array clear, so it maps onto block RAM.
- Sits between the matrix controller FSM and the MAC datapath; one instance per matrix operand or result.

Parameters:
- WIDTH, 18, data word width in bits.
- DEPTH, 32, number of words; must be a power of two, at least 2. AW = $clog2(DEPTH) is a derived localparam.
- CLEAR_VAL, 0, value written to every word during a clear sweep; WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- clear  in  1  soft-clear request pulse; starts a clear sweep.
- data_in  in  WIDTH  write data.
- wr_addr  in  AW  write address.
- mem_write  in  1  write enable.
- rd_addr  in  AW  read address.
- mem_read  in  1  read request.
- rd_limit  in  AW  highest readable address, inclusive; sampled with mem_read.
- out  out  WIDTH  registered read data.
- out_valid  out  1  high exactly one cycle per accepted read.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset: rst sampled low at posedge clk gives state=CLEAR, clr_ptr=0, out=0, out_valid=0, busy=1. Array contents are not touched in the reset cycle.
- CLEAR state:
  - Each cycle mem[clr_ptr] <= CLEAR_VAL and clr_ptr increments.
  - After the cycle that writes DEPTH-1, state goes to RUN and busy=0 on the next edge.
  - Sweep takes exactly DEPTH cycles after rst returns high.
  - mem_write and mem_read are ignored; out_valid stays 0; out holds its value.
- RUN state, write: mem_write=1 gives mem[wr_addr] <= data_in at the edge.
- RUN state, read: mem_read=1 at edge N gives, at edge N+1, out_valid=1 and out = mem[rd_addr] if rd_addr <= rd_limit, else out = 0.
  - A read to an out-of-range address still raises out_valid.
  - mem_read=0 gives out_valid=0 and out holds its last value.
- Back-to-back reads every cycle are supported; throughput is 1 read per cycle.
- Write and read in the same cycle to different addresses are independent.
- Write and read in the same cycle to the same address: see the optional feature.
- clear=1 in RUN: state goes to CLEAR, clr_ptr=0, busy=1.
  - A mem_write or mem_read in the same cycle is dropped; clear wins.
  - A read accepted in the previous cycle still completes normally.
- clear=1 while already in CLEAR: ignored; the sweep continues.
- rst low mid-sweep: sweep restarts at address 0.
- rst low in RUN with a read pending: out_valid=0 and out=0 on that edge; the pending read is lost.
- Address width is exactly AW bits, so there is no out-of-array write; wrap-around cannot occur.
- No combinational path from inputs to out.

Optional Feature:
- Macro: PARAM_DATA_MEM_BYPASS_EN.
- Defined: a same-cycle write and read to the same address in RUN returns the new data_in on out at N+1 (write-first). The rd_limit check is still applied; out-of-range gives 0.
- Not defined: the same case returns the old stored word (read-first).
- Non-colliding behaviour is identical in both builds.

Test Plan:
- Reset sweep: hold rst=0 for 2 cycles, then release; busy=1 for exactly 32 cycles, then 0. Reading addresses 0, 15 and 31 with rd_limit=31 gives out=0 with out_valid pulsing.
- Write/read with latency: write 18'h2A5A5 to address 5; read address 5 on the next cycle with rd_limit=8; out=18'h2A5A5 and out_valid=1 exactly one cycle after mem_read.
- Limit check: write 18'h00123 to address 9, then read it with rd_limit=8; out=0 and out_valid=1. Repeat with rd_limit=9; out=18'h00123.
- Collision: in one cycle, write 18'h3FFFF to address 3 (previously 18'h00011) and read address 3. Without the macro, out=18'h00011; with PARAM_DATA_MEM_BYPASS_EN, out=18'h3FFFF.
- Soft clear with dropped write: fill addresses 0-31 with a nonzero pattern, pulse clear together with a write of 18'h00077 to address 2. busy stays high for 32 cycles; afterwards every address reads 0, including address 2.
- Reset mid-sweep: pulse clear, assert rst=0 at sweep cycle 10, then release. busy stays high for a full 32 cycles after release; mem_read issued during busy produces no out_valid.

Source files
------------

// File: rtl/param_data_mem.sv
// Parametrised data memory for matrix operand/result storage.
// Registered 1-cycle reads with a valid strobe, an inclusive read-address bound,
// and a sequential clear sweep (one word per cycle) so the array maps onto block RAM.
// Optional build macro PARAM_DATA_MEM_BYPASS_EN: a same-cycle write/read to one
// address returns the new write data (write-first); without it the old word is returned.
module param_data_mem #(
  parameter int unsigned           WIDTH     = 18,
  parameter int unsigned           DEPTH     = 32,
  parameter logic [WIDTH-1:0]      CLEAR_VAL = '0,
  localparam int unsigned          AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    wr_addr,
  input  logic             mem_write,
  input  logic [AW-1:0]    rd_addr,
  input  logic             mem_read,
  input  logic [AW-1:0]    rd_limit,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_clr_ptr, w_clr_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic             w_run;
  logic             w_wr_go;
  logic             w_rd_go;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rd_data;

  // In RUN, a clear request takes priority and drops any same-cycle access.
  assign w_run   = (r_state == S_RUN);
  assign w_wr_go = w_run && mem_write && !clear;
  assign w_rd_go = w_run && mem_read  && !clear;

  // Single shared write port: the sweep and user writes never overlap in time.
  assign w_we    = rst && ((r_state == S_CLEAR) || w_wr_go);
  assign w_waddr = w_run ? wr_addr : r_clr_ptr;
  assign w_wdata = w_run ? data_in : CLEAR_VAL;

`ifdef PARAM_DATA_MEM_BYPASS_EN
  logic w_collide;
  assign w_collide = w_wr_go && (wr_addr == rd_addr);
  assign w_rd_data = w_collide ? data_in : r_mem[rd_addr];
`else
  assign w_rd_data = r_mem[rd_addr];
`endif

  // State and sweep pointer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next-state logic: sweep every address once, then serve accesses until cleared.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    unique case (r_state)
      S_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clear) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // Array write port; no reset so it stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read with bound check; out holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_rd_go) begin
      r_out_valid <= 1'b1;
      r_out       <= (rd_addr <= rd_limit) ? w_rd_data : '0;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_CLEAR);

endmodule
